// File: rtl/mult8_seq_ctrl_if.sv
// Request/result bundle for the sequential 8x8 multiplier: operands and start
// from the requester, product with a valid/ack handshake back to the consumer.
interface mult8_seq_ctrl_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        prod_valid;
  logic [15:0] prod;
  logic        prod_ack;

  modport master (
    output start, a, b, prod_ack,
    input  busy, prod_valid, prod
  );

  modport slave (
    input  start, a, b, prod_ack,
    output busy, prod_valid, prod
  );
endinterface

// File: rtl/mult8_seq_ctrl.sv
// Unsigned 8x8 multiply built by stepping one 4x4 array multiplier across the
// four nibble pairs and accumulating the shifted partial products.
module ArrMult_4bit (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  output logic [7:0] p_o
);
  logic [7:0] row0, row1, row2, row3;

  assign row0 = y_i[0] ? {4'h0, x_i}       : 8'h00;
  assign row1 = y_i[1] ? {3'h0, x_i, 1'b0} : 8'h00;
  assign row2 = y_i[2] ? {2'h0, x_i, 2'h0} : 8'h00;
  assign row3 = y_i[3] ? {1'b0, x_i, 3'h0} : 8'h00;
  assign p_o  = row0 + row1 + row2 + row3;
endmodule

module mult8_seq_ctrl #(
  parameter int ZERO_SKIP = 1
) (
  input  logic            clk,
  input  logic            rst,
  mult8_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  ar_q, ar_d;
  logic [7:0]  br_q, br_d;
  logic [15:0] prod_q, prod_d;
  logic        valid_q, valid_d;

  logic [3:0]  mulX, mulY;
  logic [7:0]  pp;
  logic [15:0] term;
  logic [15:0] accSum;
  logic        accept;
  logic        zeroOp;

  ArrMult_4bit u_mult (
    .x_i (mulX),
    .y_i (mulY),
    .p_o (pp)
  );

  // Nibble selection and shift for the current step; steps 1 and 2 share weight 2^4.
  always_comb begin
    mulX = ar_q[3:0];
    mulY = br_q[3:0];
    term = {8'h00, pp};
    case (step_q)
      2'd1: begin
        mulX = ar_q[7:4];
        term = {4'h0, pp, 4'h0};
      end
      2'd2: begin
        mulY = br_q[7:4];
        term = {4'h0, pp, 4'h0};
      end
      2'd3: begin
        mulX = ar_q[7:4];
        mulY = br_q[7:4];
        term = {pp, 8'h00};
      end
      default: ;
    endcase
  end

  assign accSum = acc_q + term;
  assign accept = bus.start && ((state_q == IDLE) || (state_q == HOLD && bus.prod_ack));
  assign zeroOp = (ZERO_SKIP != 0) && ((bus.a == 8'h00) || (bus.b == 8'h00));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    ar_d    = ar_q;
    br_d    = br_q;
    prod_d  = prod_q;
    valid_d = valid_q;

    case (state_q)
      CALC: begin
        acc_d  = accSum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          prod_d  = accSum;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.prod_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    // A new request overrides the HOLD release; a zero operand skips CALC.
    if (accept) begin
      ar_d   = bus.a;
      br_d   = bus.b;
      acc_d  = 16'h0000;
      step_d = 2'd0;
      if (zeroOp) begin
        prod_d  = 16'h0000;
        valid_d = 1'b1;
        state_d = HOLD;
      end else begin
        valid_d = 1'b0;
        state_d = CALC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      acc_q   <= 16'h0000;
      ar_q    <= 8'h00;
      br_q    <= 8'h00;
      prod_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      ar_q    <= ar_d;
      br_q    <= br_d;
      prod_q  <= prod_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.prod_valid = valid_q;
  assign bus.prod       = prod_q;
endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Scoreboard bench for mult8_seq_ctrl: one instance with zero-skip enabled,
// a second with it disabled for the latency comparison.
module tb_mult8_seq_ctrl;
  logic clk;
  logic rst;

  mult8_seq_ctrl_if bus ();
  mult8_seq_ctrl_if bus0 ();

  mult8_seq_ctrl #(.ZERO_SKIP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mult8_seq_ctrl #(.ZERO_SKIP(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  int testsRun;
  int testsFailed;
  logic [15:0] expQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic startOp(input logic [7:0] aa, input logic [7:0] bb);
    bus.a     = aa;
    bus.b     = bb;
    bus.start = 1'b1;
    expQ.push_back(16'(aa) * 16'(bb));
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic waitValid(input int maxCyc, output bit ok, output int lat);
    lat = 0;
    while (!bus.prod_valid && lat < maxCyc) begin
      cycle();
      lat++;
    end
    ok = bus.prod_valid;
  endtask

  task automatic ackOnly();
    bus.prod_ack = 1'b1;
    cycle();
    bus.prod_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      cycle();
      testsRun++;
      if ({bus.busy, bus.prod_valid, bus.prod} !== 18'h0) begin
        testsFailed++;
        $display("[TB] FAIL reset_state busy=%b valid=%b prod=%h expected 0/0/0000",
                 bus.busy, bus.prod_valid, bus.prod);
      end
    end
    rst = 1'b0;
    bus.start = 1'b0;
    cycle();
    testsRun++;
    if (bus.busy !== 1'b0 || dut0.bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_no_accept busy=%b busy0=%b expected 0", bus.busy, bus0.busy);
    end
  endtask

  task automatic test_full_range();
    logic [15:0] e;
    startOp(8'hFF, 8'hFF);
    e = expQ.pop_front();
    for (int i = 1; i <= 4; i++) begin
      testsRun++;
      if (bus.prod_valid !== 1'b0 || bus.busy !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL full_latency cyc=%0d valid=%b busy=%b expected 0/1",
                 i - 1, bus.prod_valid, bus.busy);
      end
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (bus.prod_valid !== 1'b1 || bus.prod !== e) begin
        testsFailed++;
        $display("[TB] FAIL full_hold cyc=%0d valid=%b prod=%h expected 1/%h",
                 i, bus.prod_valid, bus.prod, e);
      end
      if (i < 3) cycle();
    end
    ackOnly();
    testsRun++;
    if (bus.busy !== 1'b0 || bus.prod_valid !== 1'b0 || bus.prod !== 16'hFE01) begin
      testsFailed++;
      $display("[TB] FAIL full_ack busy=%b valid=%b prod=%h expected 0/0/fe01",
               bus.busy, bus.prod_valid, bus.prod);
    end
  endtask

  task automatic test_zero_skip();
    logic [15:0] e;
    startOp(8'h00, 8'h5A);
    e = expQ.pop_front();
    testsRun++;
    if (bus.prod_valid !== 1'b1 || bus.prod !== e) begin
      testsFailed++;
      $display("[TB] FAIL zero_skip valid=%b prod=%h expected 1/%h", bus.prod_valid, bus.prod, e);
    end
    ackOnly();

    bus0.a = 8'h00;
    bus0.b = 8'h5A;
    bus0.start = 1'b1;
    cycle();
    bus0.start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      testsRun++;
      if (bus0.prod_valid !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL noskip_latency cyc=%0d valid=%b expected 0", i - 1, bus0.prod_valid);
      end
      cycle();
    end
    testsRun++;
    if (bus0.prod_valid !== 1'b1 || bus0.prod !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL noskip_result valid=%b prod=%h expected 1/0000",
               bus0.prod_valid, bus0.prod);
    end
    bus0.prod_ack = 1'b1;
    cycle();
    bus0.prod_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    bit ok;
    int lat;
    startOp(8'h05, 8'h06);
    waitValid(6, ok, lat);
    e = expQ.pop_front();
    testsRun++;
    if (!ok || bus.prod !== e) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first ok=%b prod=%h expected %h", ok, bus.prod, e);
    end
    bus.prod_ack = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'h12;
    bus.b = 8'h34;
    expQ.push_back(16'h03A8);
    cycle();
    bus.prod_ack = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (bus.prod_valid !== 1'b0 || bus.busy !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL b2b_gap cyc=%0d valid=%b busy=%b expected 0/1",
                 i, bus.prod_valid, bus.busy);
      end
      cycle();
    end
    e = expQ.pop_front();
    testsRun++;
    if (bus.prod_valid !== 1'b1 || bus.prod !== e) begin
      testsFailed++;
      $display("[TB] FAIL b2b_result valid=%b prod=%h expected 1/%h", bus.prod_valid, bus.prod, e);
    end
    ackOnly();

    // A start while CALC is running must not disturb the in-flight product.
    startOp(8'h21, 8'h02);
    bus.a = 8'h0F;
    bus.b = 8'h10;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    waitValid(6, ok, lat);
    e = expQ.pop_front();
    testsRun++;
    if (!ok || bus.prod !== e) begin
      testsFailed++;
      $display("[TB] FAIL calc_start_ignored ok=%b prod=%h expected %h", ok, bus.prod, e);
    end
    ackOnly();
    testsRun++;
    if (bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL calc_start_idle busy=%b expected 0", bus.busy);
    end
    startOp(8'h0F, 8'h10);
    waitValid(6, ok, lat);
    e = expQ.pop_front();
    testsRun++;
    if (!ok || bus.prod !== e || e !== 16'h00F0) begin
      testsFailed++;
      $display("[TB] FAIL idle_start ok=%b prod=%h expected 00f0", ok, bus.prod);
    end
    ackOnly();
  endtask

  task automatic test_mid_op_reset();
    logic [15:0] e;
    bit ok;
    int lat;
    bus.a = 8'hA5;
    bus.b = 8'h3C;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    testsRun++;
    if (bus.busy !== 1'b0 || bus.prod_valid !== 1'b0 || bus.prod !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL midop_reset busy=%b valid=%b prod=%h expected 0/0/0000",
               bus.busy, bus.prod_valid, bus.prod);
    end
    startOp(8'h03, 8'h07);
    waitValid(6, ok, lat);
    e = expQ.pop_front();
    testsRun++;
    if (!ok || lat != 4 || bus.prod !== e) begin
      testsFailed++;
      $display("[TB] FAIL midop_fresh ok=%b lat=%0d prod=%h expected lat 4 prod %h",
               ok, lat, bus.prod, e);
    end
    ackOnly();
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    logic [15:0] e;
    bit ok;
    int lat;
    int dly;
    for (int i = 0; i < 2000; i++) begin
      ra = (i < 4) ? ((i[0]) ? 8'hFF : 8'h01) : 8'($urandom);
      rb = (i < 4) ? ((i[1]) ? 8'h80 : 8'hFF) : 8'($urandom);
      if (i > 0 && $urandom_range(0, 1) == 1) begin
        bus.prod_ack = 1'b1;
        bus.start = 1'b1;
        bus.a = ra;
        bus.b = rb;
        expQ.push_back(16'(ra) * 16'(rb));
        cycle();
        bus.prod_ack = 1'b0;
        bus.start = 1'b0;
      end else begin
        if (i > 0) ackOnly();
        startOp(ra, rb);
      end
      waitValid(6, ok, lat);
      e = expQ.pop_front();
      testsRun++;
      if (!ok || bus.prod !== e) begin
        testsFailed++;
        $display("[TB] FAIL rand_prod a=%h b=%h ok=%b prod=%h expected %h", ra, rb, ok, bus.prod, e);
      end
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) cycle();
      testsRun++;
      if (bus.prod_valid !== 1'b1 || bus.prod !== e) begin
        testsFailed++;
        $display("[TB] FAIL rand_stable a=%h b=%h valid=%b prod=%h expected 1/%h",
                 ra, rb, bus.prod_valid, bus.prod, e);
      end
    end
    ackOnly();
    testsRun++;
    if (expQ.size() != 0 || bus.prod_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rand_drain queue=%0d valid=%b expected 0/0", expQ.size(), bus.prod_valid);
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.prod_ack = 1'b0;
    bus0.start = 1'b0;
    bus0.a = 8'h00;
    bus0.b = 8'h00;
    bus0.prod_ack = 1'b0;
    test_reset();
    test_full_range();
    test_zero_skip();
    test_back_to_back();
    test_mid_op_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
